s_mem_check: RTL
================

# s_mem_check

Read-side companion to the S-memory initialiser: after `init` writes S[i]=i into the 256×8 S RAM, this block walks the same RAM through its read port and verifies the contents. It sits beside `init` under `task1` and shares the S RAM's address mux. It uses the same rdy/en start protocol as `init`, so the top-level FSM sequences it the same way. It reports pass/fail, an error count and the first mismatch.

## Interface
Parameters:
- `DEPTH`, 256: number of S locations checked; the address width is fixed at 8.

Ports:
- `clk` in 1: system clock (`CLOCK_50` at top).
- `rst_n` in 1: reset, asynchronous, active-low (`KEY[3]` at top).
- `en` in 1: start request; sampled only while `rdy`=1.
- `rdy` out 1: idle and able to accept `en`.
- `addr` out 8: S RAM read address.
- `rddata` in 8: S RAM read data, valid one cycle after `addr`.
- `done` out 1: one-cycle pulse when results are final.
- `pass` out 1: last run had zero mismatches; held until the next start.
- `err_cnt` out 9: number of mismatches in the last run, 0..256.
- `fail_addr` out 8: address of the first mismatch.
- `fail_data` out 8: data read at the first mismatch.
- `perm_ok` out 1: contents form a permutation of 0..255 (see Configuration).

## Operation
- States: IDLE → READ → DRAIN → DONE → IDLE.
- IDLE:
  - `rdy`=1.
  - On `en`=1, clear `pass`, `err_cnt`, `fail_*`, the bitmap and the address counter, then go to READ.
- READ:
  - Drive `addr`=i for i=0..255, one address per cycle.
  - In the same cycle, compare `rddata` (for address i-1) against i-1.
  - After `addr`=255 is issued, go to DRAIN.
- DRAIN: compare the data for address 255, then go to DONE.
- DONE:
  - Pulse `done`.
  - Set `pass` = (`err_cnt`==0).
  - Go to IDLE.
- Mismatch rule: if `rddata` != expected address, increment `err_cnt`. If it is the first mismatch of the run, latch `fail_addr`/`fail_data`.
- Width rules:
  - The address counter is 9 bits internally so terminal detection does not wrap.
  - `err_cnt` is 9 bits and cannot overflow, because the maximum is 256.
- `en` asserted while `rdy`=0 is ignored; no queuing.
- `addr` holds 0 in IDLE.

## Timing
- Reset values: `rdy`=1, `addr`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_addr`=0, `fail_data`=0, `perm_ok`=0. State is IDLE.
- Handshake:
  - `en` is sampled at edge E while `rdy`=1.
  - `rdy` is low from E+1 until the cycle after the `done` pulse.
- Latency:
  - `addr`=0 is driven in cycle E+1, and `addr`=255 in E+256.
  - The last compare happens in E+257.
  - `done`=1 and the final `pass`/`err_cnt` are visible in E+258.
  - `rdy`=1 from E+259.
  - Total: 259 cycles from accepted `en` to `rdy`.
- Back-to-back: `en` held high restarts in the first cycle `rdy`=1.
- Reset mid-run: asynchronously returns to reset values. There is no partial `done` and no stale results.

## Configuration
- `S_MEM_PERM_CHECK_EN` defined:
  - Compiles in a 256-bit seen bitmap.
  - Each compare sets bit[`rddata`].
  - A repeat hit clears an internal perm flag.
  - In DONE, `perm_ok` is set to (no repeat hit seen).
  - Intended for reuse after key scheduling, when the identity check is expected to fail.
- Undefined: no bitmap; `perm_ok` is tied to 0.
- Identity checking is always present.

## Structure
- `arc4_pkg` holds:
  - the state enum (`CHK_IDLE`, `CHK_READ`, `CHK_DRAIN`, `CHK_DONE`);
  - the constants `S_DEPTH`=256 and `S_AW`=8.
- Sub-module `perm_bitmap`, instantiated only under the macro:
  - inputs: clear, set-valid, 8-bit value;
  - output: dup flag.

## Test plan
- S RAM preloaded with identity, pulse `en` → `done` at E+258, `pass`=1, `err_cnt`=0, `rdy` back at E+259.
- S[0x37]=0x00 and S[0xA2]=0xFF, rest identity → `pass`=0, `err_cnt`=2, `fail_addr`=0x37, `fail_data`=0x00.
- All S=0x00 → `err_cnt`=255 (only address 0 matches), `fail_addr`=0x01. With the macro, `perm_ok`=0.
- S reversed (S[i]=255-i), macro on → `err_cnt`=256, `perm_ok`=1, `pass`=0.
- `rst_n` pulled low at E+100 → all outputs at reset values immediately, no `done`. A fresh `en` then completes normally with `pass`=1.
- `en` re-pulsed at E+50 while busy → ignored, exactly one `done`. `en` held high → second run starts at E+259.

Source files
------------

// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arc4_pkg
// Brief    : Shared S-memory constants and checker state encoding.
// Revision : 1.0
// ============================================================================
package arc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int S_AW    = 8;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_READ  = 2'd1,
        CHK_DRAIN = 2'd2,
        CHK_DONE  = 2'd3
    } chk_state_e;

endpackage
`default_nettype wire

// File: rtl/s_mem_check_if.sv
`default_nettype none
// ============================================================================
// Module   : s_mem_check_if
// Brief    : Start handshake, S RAM read port and result bus of s_mem_check.
// Revision : 1.0
// ============================================================================
interface s_mem_check_if;
    import arc4_pkg::*;

    logic              en;
    logic              rdy;
    logic [S_AW-1:0]   addr;
    logic [S_AW-1:0]   rddata;
    logic              done;
    logic              pass;
    logic [S_AW:0]     err_cnt;
    logic [S_AW-1:0]   fail_addr;
    logic [S_AW-1:0]   fail_data;
    logic              perm_ok;

    modport master (
        output en, rddata,
        input  rdy, addr, done, pass, err_cnt, fail_addr, fail_data, perm_ok
    );

    modport slave (
        input  en, rddata,
        output rdy, addr, done, pass, err_cnt, fail_addr, fail_data, perm_ok
    );
endinterface
`default_nettype wire

// File: rtl/perm_bitmap.sv
`default_nettype none
// ============================================================================
// Module   : perm_bitmap
// Brief    : Seen-value bitmap; dup flags any value observed twice since clear.
// Revision : 1.0
// ============================================================================
module perm_bitmap
    import arc4_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            clear,
    input  wire logic            set_valid,
    input  wire logic [S_AW-1:0] value,
    output logic                 dup
);
    logic [S_DEPTH-1:0] r_seen;
    logic               r_dup;
    logic               w_hit;

    assign w_hit = set_valid && r_seen[value];
    // Include the current hit so the owner can latch the verdict on the last compare.
    assign dup   = r_dup || w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen <= '0;
            r_dup  <= 1'b0;
        end else if (clear) begin
            r_seen <= '0;
            r_dup  <= 1'b0;
        end else if (set_valid) begin
            r_seen[value] <= 1'b1;
            if (w_hit) begin
                r_dup <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/s_mem_check.sv
`default_nettype none
// ============================================================================
// Module   : s_mem_check
// Brief    : Walks the S RAM and verifies S[i]==i; reports pass, error count
//            and first mismatch. S_MEM_PERM_CHECK_EN adds a permutation check.
// Revision : 1.0
// ============================================================================
module s_mem_check
    import arc4_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    s_mem_check_if.slave  bus
);
    localparam logic [S_AW:0] C_LAST = (S_AW+1)'(DEPTH - 1);

    chk_state_e        r_state;
    chk_state_e        w_state_next;
    logic [S_AW:0]     r_cnt;
    logic [S_AW:0]     r_err_cnt;
    logic [S_AW:0]     w_err_next;
    logic [S_AW-1:0]   r_fail_addr;
    logic [S_AW-1:0]   r_fail_data;
    logic [S_AW-1:0]   w_exp;
    logic              r_pass;
    logic              r_perm_ok;
    logic              w_perm_next;
    logic              w_rdy;
    logic              w_done;
    logic              w_start;
    logic              w_cmp_valid;
    logic              w_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CHK_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rdy        = 1'b0;
        w_done       = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            CHK_IDLE: begin
                w_rdy = 1'b1;
                if (bus.en) begin
                    w_start      = 1'b1;
                    w_state_next = CHK_READ;
                end
            end
            CHK_READ: begin
                if (r_cnt == C_LAST) begin
                    w_state_next = CHK_DRAIN;
                end
            end
            CHK_DRAIN: w_state_next = CHK_DONE;
            CHK_DONE: begin
                w_done       = 1'b1;
                w_state_next = CHK_IDLE;
            end
            default:   w_state_next = CHK_IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so the compare targets r_cnt-1.
    assign w_cmp_valid = ((r_state == CHK_READ) && (r_cnt != '0)) || (r_state == CHK_DRAIN);
    assign w_exp       = S_AW'(r_cnt - 1'b1);
    assign w_mismatch  = w_cmp_valid && (bus.rddata != w_exp);
    assign w_err_next  = r_err_cnt + {{S_AW{1'b0}}, w_mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_pass      <= 1'b0;
            r_perm_ok   <= 1'b0;
        end else if (w_start) begin
            r_cnt       <= '0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_pass      <= 1'b0;
            r_perm_ok   <= 1'b0;
        end else begin
            if (r_state == CHK_READ) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_mismatch) begin
                r_err_cnt <= w_err_next;
                if (r_err_cnt == '0) begin
                    r_fail_addr <= w_exp;
                    r_fail_data <= bus.rddata;
                end
            end
            // Verdict folds in the final compare so it is visible with done.
            if (r_state == CHK_DRAIN) begin
                r_pass    <= (w_err_next == '0);
                r_perm_ok <= w_perm_next;
            end
        end
    end

`ifdef S_MEM_PERM_CHECK_EN
    logic w_dup;

    perm_bitmap u_perm_bitmap (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_start),
        .set_valid (w_cmp_valid),
        .value     (bus.rddata),
        .dup       (w_dup)
    );

    assign w_perm_next = !w_dup;
`else
    assign w_perm_next = 1'b0;
`endif

    assign bus.rdy       = w_rdy;
    assign bus.done      = w_done;
    assign bus.addr      = (r_state == CHK_READ) ? r_cnt[S_AW-1:0] : '0;
    assign bus.pass      = r_pass;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.fail_addr = r_fail_addr;
    assign bus.fail_data = r_fail_data;
    assign bus.perm_ok   = r_perm_ok;
endmodule
`default_nettype wire
